rx_iq_byte_packer: RTL and testbench

Downstream of the receiver decimation/FIR chain. Captures each 24-bit I/Q output sample on the chain's strobe and buffers it in a small sample FIFO. Serialises every sample into six bytes on a valid/ready byte stream toward the host (Raspberry Pi) transfer interface. Drops samples on overflow and reports them, so the host can detect gaps in the WSPR baseband stream.

---
 rtl/rx_iq_byte_packer.sv | 150 +++++++++++++++
 tb/tb_rx_iq_byte_packer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_byte_packer.sv
// rx_iq_byte_packer
//   Captures 24-bit I/Q samples from the decimation/FIR chain into a small
//   sample FIFO and serialises each sample as six bytes on a valid/ready
//   stream toward the host. Samples that arrive while the FIFO is full are
//   dropped and counted so the host can detect gaps in the baseband stream.
//
// Ports
//   clock, reset         receiver clock; asynchronous active-high reset
//   in_strobe/in_I/in_Q  one-cycle sample-valid with signed I and Q samples
//   out_data/out_valid   byte stream toward the host
//   out_ready            consumer accepts the current byte
//   out_last             marks the 6th byte of a sample
//   fifo_level           samples waiting in the FIFO (not the one being sent)
//   overflow             sticky flag: at least one sample was dropped
//   drop_count           saturating count of dropped samples
//   clear_overflow       clears overflow and drop_count
module rx_iq_byte_packer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DROPW = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_strobe,
  input  logic signed [23:0]  in_I,
  input  logic signed [23:0]  in_Q,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [AW:0]         fifo_level,
  output logic                overflow,
  output logic [DROPW-1:0]    drop_count,
  input  logic                clear_overflow
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [47:0]       sample_q, sample_d;
  logic [47:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q;
  logic              ovf_q;
  logic [DROPW-1:0]  drop_q;

  logic              has_data;
  logic              last_accept;
  logic              pop;
  logic              push;
  logic              drop;

  assign has_data    = (level_q != '0);
  assign last_accept = (state_q == S_SEND) && out_ready && (idx_q == 3'd5);
  assign pop         = has_data && ((state_q == S_IDLE) || last_accept);
  // A full FIFO still accepts a sample when the head leaves on the same edge.
  assign push        = in_strobe && ((level_q != FULL_LEVEL) || pop);
  assign drop        = in_strobe && !push;

  // Serialiser next-state and byte outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sample_d  = sample_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d  = S_SEND;
          idx_d    = 3'd0;
          sample_d = mem_q[rd_ptr_q];
        end
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = (idx_q == 3'd5);
        case (idx_q)
          3'd0:    out_data = sample_q[47:40];
          3'd1:    out_data = sample_q[39:32];
          3'd2:    out_data = sample_q[31:24];
          3'd3:    out_data = sample_q[23:16];
          3'd4:    out_data = sample_q[15:8];
          default: out_data = sample_q[7:0];
        endcase
        if (out_ready) begin
          if (idx_q == 3'd5) begin
            // Chain straight into the next sample so the stream has no bubble.
            if (pop) begin
              idx_d    = 3'd0;
              sample_d = mem_q[rd_ptr_q];
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: serialiser, pointers, level, overflow tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // A drop on the same edge as a clear leaves exactly that one drop counted.
      if (drop) begin
        ovf_q <= 1'b1;
        if (clear_overflow)      drop_q <= DROPW'(1);
        else if (drop_q != '1)   drop_q <= drop_q + 1'b1;
      end else if (clear_overflow) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  // Sample storage: data only, never reset; out_data is gated by state.
  always_ff @(posedge clock) begin
    sample_q <= sample_d;
    if (push) mem_q[wr_ptr_q] <= {in_I, in_Q};
  end

  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_rx_iq_byte_packer.sv
module tb_rx_iq_byte_packer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DROPW = 16;
  localparam int DMAX  = (1 << DROPW) - 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_strobe = 1'b0;
  logic signed [23:0] in_I = '0;
  logic signed [23:0] in_Q = '0;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               out_last;
  logic [AW:0]        fifo_level;
  logic               overflow;
  logic [DROPW-1:0]   drop_count;
  logic               clear_overflow = 1'b0;

  rx_iq_byte_packer #(.DEPTH(DEPTH), .AW(AW), .DROPW(DROPW)) dut (
    .clock(clock), .reset(reset), .in_strobe(in_strobe), .in_I(in_I), .in_Q(in_Q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count),
    .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [47:0] s, input int k);
    return s[47 - 8*k -: 8];
  endfunction

  // Reference model: a queue of waiting samples plus the sample being sent.
  logic [47:0] mq[$];
  logic [47:0] m_cur = '0;
  logic [47:0] m_popped = '0;
  int          m_idx = 0;
  bit          m_busy = 0;
  bit          m_ovf = 0;
  int          m_dc = 0;
  bit          m_pop, m_push;

  always @(negedge clock) begin
    if (reset) begin
      mq.delete();
      m_busy = 0; m_idx = 0; m_cur = '0; m_ovf = 0; m_dc = 0;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      check("rst_level", fifo_level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_count, 0);
    end else begin
      check("valid", out_valid, m_busy);
      check("data", out_data, m_busy ? byte_of(m_cur, m_idx) : 8'h00);
      check("last", out_last, m_busy && m_idx == 5);
      check("level", fifo_level, mq.size());
      check("ovf", overflow, m_ovf);
      check("drop", drop_count, m_dc);
      m_pop  = (mq.size() > 0) && (!m_busy || (out_ready && m_idx == 5));
      m_push = in_strobe && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) m_popped = mq.pop_front();
      if (m_push) mq.push_back({in_I, in_Q});
      if (m_busy && out_ready) begin
        if (m_idx == 5) begin
          if (m_pop) begin m_cur = m_popped; m_idx = 0; end
          else m_busy = 0;
        end else m_idx++;
      end else if (!m_busy && m_pop) begin
        m_busy = 1; m_cur = m_popped; m_idx = 0;
      end
      if (in_strobe && !m_push) begin
        m_ovf = 1;
        if (clear_overflow) m_dc = 1;
        else if (m_dc < DMAX) m_dc++;
      end else if (clear_overflow) begin
        m_ovf = 0; m_dc = 0;
      end
    end
  end

  // Record accepted bytes for model-independent checks.
  logic [7:0] cap_d[$];
  bit         cap_l[$];
  int         cap_t[$];
  int         cyc = 0;
  int         maxlvl = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      cap_d.push_back(out_data);
      cap_l.push_back(out_last);
      cap_t.push_back(cyc);
    end
    if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [23:0] i, input logic [23:0] q);
    in_strobe = 1'b1; in_I = i; in_Q = q;
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic cap_clear();
    cap_d.delete(); cap_l.delete(); cap_t.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0]  exp1 [6];
  logic [47:0] expq[$];
  logic [47:0] got;
  int          rp;

  initial begin
    exp1[0] = 8'h12; exp1[1] = 8'h34; exp1[2] = 8'h56;
    exp1[3] = 8'hAB; exp1[4] = 8'hCD; exp1[5] = 8'hEF;

    // Reset
    repeat (3) tick();
    check("init_level", fifo_level, 0);
    check("init_valid", out_valid, 0);
    reset = 1'b0;
    tick();

    // Single sample: latency and byte order
    out_ready = 1'b1;
    cap_clear();
    strobe(24'h123456, 24'hABCDEF);
    check("lat_level_t0", fifo_level, 1);
    check("lat_valid_t0", out_valid, 0);
    tick();
    check("lat_valid_t1", out_valid, 1);
    check("lat_byte0", out_data, 8'h12);
    check("lat_level_t1", fifo_level, 0);
    repeat (8) tick();
    check("t1_count", cap_d.size(), 6);
    if (cap_d.size() == 6)
      for (int k = 0; k < 6; k++) begin
        check("t1_byte", cap_d[k], exp1[k]);
        check("t1_last", cap_l[k], k == 5);
      end
    check("t1_idle", out_valid, 0);

    // Back-to-back samples: no bubble
    cap_clear();
    maxlvl = 0;
    strobe(24'h800001, 24'h7FFFFE);
    repeat (5) tick();
    strobe(24'hFFFFFF, 24'h000000);
    repeat (14) tick();
    check("t2_count", cap_d.size(), 12);
    if (cap_d.size() == 12) begin
      check("t2_last6", cap_l[5], 1);
      check("t2_last12", cap_l[11], 1);
      check("t2_contig", cap_t[11] - cap_t[0], 11);
      check("t2_b6", cap_d[6], 8'hFF);
    end
    check("t2_maxlvl", maxlvl <= 1, 1);

    // Stall at byte index 2
    strobe(24'h123456, 24'hABCDEF);
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (10) begin
      tick();
      check("t3_hold_data", out_data, 8'h56);
      check("t3_hold_last", out_last, 0);
    end
    out_ready = 1'b1;
    tick();
    check("t3_resume", out_data, 8'hAB);
    repeat (6) tick();

    // Overflow: one in serialiser, sixteen queued, one dropped
    out_ready = 1'b0;
    cap_clear();
    expq.delete();
    for (int k = 0; k < 18; k++) begin
      got = {$urandom(), $urandom()};
      if (k < 17) expq.push_back(got);
      strobe(got[47:24], got[23:0]);
    end
    check("t4_level", fifo_level, 16);
    check("t4_ovf", overflow, 1);
    check("t4_drop", drop_count, 1);
    out_ready = 1'b1;
    repeat (17*6 + 4) tick();
    check("t4_count", cap_d.size(), 102);
    if (cap_d.size() == 102)
      for (int s = 0; s < 17; s++) begin
        got = {cap_d[6*s], cap_d[6*s+1], cap_d[6*s+2], cap_d[6*s+3], cap_d[6*s+4], cap_d[6*s+5]};
        check("t4_sample", got, expq[s]);
      end

    // Clear, then drop coinciding with clear
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t5_clr_ovf", overflow, 0);
    check("t5_clr_drop", drop_count, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++) strobe(24'(k), 24'(k + 100));
    check("t5_full", fifo_level, 16);
    check("t5_noovf", overflow, 0);
    clear_overflow = 1'b1;
    strobe(24'h0BAD00, 24'h00BAD0);
    check("t5_both_ovf", overflow, 1);
    check("t5_both_drop", drop_count, 1);
    tick();
    clear_overflow = 1'b0;
    check("t5_lone_ovf", overflow, 0);
    check("t5_lone_drop", drop_count, 0);

    // Asynchronous reset in mid-sample with samples queued
    out_ready = 1'b1;
    repeat (3) tick();
    #1 reset = 1'b1;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_data", out_data, 0);
    check("t6_last", out_last, 0);
    check("t6_level", fifo_level, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) begin
      tick();
      check("t6_quiet", out_valid, 0);
    end
    strobe(24'hFEDCBA, 24'h010203);
    tick();
    check("t6_new_valid", out_valid, 1);
    check("t6_new_byte", out_data, 8'hFE);
    repeat (8) tick();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rp = ((c / 300) % 2) ? 20 : 85;
      in_strobe      = ($urandom_range(0, 99) < 25);
      in_I           = 24'($urandom());
      in_Q           = 24'($urandom());
      out_ready      = ($urandom_range(0, 99) < rp);
      clear_overflow = ($urandom_range(0, 149) == 0);
      tick();
    end
    in_strobe = 1'b0;
    clear_overflow = 1'b0;
    out_ready = 1'b1;
    repeat (150) tick();
    check("end_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
